// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU request/grant ports and CDB broadcast bundle
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int ID_W   = 4,
  parameter int VAL_W  = 8
);
  logic [NUM_FU-1:0]            fu_req;
  logic [NUM_FU-1:0]            fu_grant;
  logic [NUM_FU-1:0][ID_W-1:0]  fu_id;
  logic [NUM_FU-1:0][VAL_W-1:0] fu_val;
  logic                         cdb_stall;
  logic                         cdb_valid;
  logic [ID_W-1:0]              cdb_id;
  logic [VAL_W-1:0]             cdb_val;
  logic [15:0]                  xfer_count;
  logic                         starve_err;
  modport master (
    output fu_req, fu_id, fu_val, cdb_stall,
    input  fu_grant, cdb_valid, cdb_id, cdb_val, xfer_count, starve_err
  );
  modport slave (
    input  fu_req, fu_id, fu_val, cdb_stall,
    output fu_grant, cdb_valid, cdb_id, cdb_val, xfer_count, starve_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of FU results onto a registered common data bus
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int ID_W       = 4,
  parameter int VAL_W      = 8,
  parameter int STARVE_LIM = 8
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_FU);
  localparam int CW = $clog2(STARVE_LIM + 2);
  logic [PW-1:0]    rr_q, rr_d, sel, j;
  logic             hit;
  logic [NUM_FU-1:0] gnt;
  logic [CW-1:0]    wait_q [NUM_FU];
  logic [CW-1:0]    wait_d [NUM_FU];
  logic             starve_q, starve_d, valid_q;
  logic [ID_W-1:0]  id_q;
  logic [VAL_W-1:0] val_q;
  logic [15:0]      cnt_q;
  always_comb begin
    sel = '0;
    hit = 1'b0;
    j   = '0;
    // scan backwards so the requester nearest rr_q is the last (winning) assignment
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      j   = PW'((int'(rr_q) + k) % NUM_FU);
      sel = bus.fu_req[j] ? j : sel;
      hit = hit | bus.fu_req[j];
    end
    hit  = hit & rst & ~bus.cdb_stall;
    gnt  = hit ? (NUM_FU'(1) << sel) : '0;
    rr_d = (int'(sel) == NUM_FU - 1) ? '0 : sel + PW'(1);
    starve_d = starve_q;
    for (int i = 0; i < NUM_FU; i++) begin
      wait_d[i] = (!bus.fu_req[i] || gnt[i]) ? '0 :
                  (!bus.cdb_stall && int'(wait_q[i]) <= STARVE_LIM) ? wait_q[i] + CW'(1) : wait_q[i];
      starve_d  = starve_d | (int'(wait_d[i]) > STARVE_LIM);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      val_q    <= '0;
      cnt_q    <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= '0;
    end else begin
      valid_q  <= hit;
      starve_q <= starve_d;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= wait_d[i];
      if (hit) begin
        rr_q  <= rr_d;
        id_q  <= bus.fu_id[sel];
        val_q <= bus.fu_val[sel];
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
  assign bus.fu_grant   = gnt;
  assign bus.cdb_valid  = valid_q;
  assign bus.cdb_id     = id_q;
  assign bus.cdb_val    = val_q;
  assign bus.xfer_count = cnt_q;
  assign bus.starve_err = starve_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
  localparam int N = 4, IW = 4, VW = 8, LIM = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cdb_arbiter_if #(.NUM_FU(N), .ID_W(IW), .VAL_W(VW)) u_if ();
  cdb_arbiter #(.NUM_FU(N), .ID_W(IW), .VAL_W(VW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave)
  );
  int checks = 0, failures = 0;
  int m_rr = 0, m_cnt = 0, m_id = 0, m_val = 0;
  bit m_valid = 1'b0, m_starve = 1'b0, chk_en = 1'b0;
  int m_wait [N];
  logic [N-1:0] last_gnt = '0;
  function automatic int pick();
    if (!rst || u_if.cdb_stall) return -1;
    for (int k = 0; k < N; k++)
      if (u_if.fu_req[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin : model
    int g;
    g = pick();
    if (!rst) begin
      m_rr = 0; m_cnt = 0; m_id = 0; m_val = 0; m_valid = 1'b0; m_starve = 1'b0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_id  = int'(u_if.fu_id[g]);
        m_val = int'(u_if.fu_val[g]);
        m_cnt = (m_cnt + 1) % 65536;
        m_rr  = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (!u_if.fu_req[i] || i == g) m_wait[i] = 0;
        else if (!u_if.cdb_stall) m_wait[i] = (m_wait[i] > LIM) ? LIM + 1 : m_wait[i] + 1;
        if (m_wait[i] > LIM) m_starve = 1'b1;
      end
    end
  end
  always @(negedge clk) begin : compare
    int g;
    if (chk_en) begin
      g = pick();
      chk("grant", 32'(u_if.fu_grant), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("valid", 32'(u_if.cdb_valid), 32'(m_valid));
      chk("id", 32'(u_if.cdb_id), 32'(m_id));
      chk("val", 32'(u_if.cdb_val), 32'(m_val));
      chk("xfer_count", 32'(u_if.xfer_count), 32'(m_cnt));
      chk("starve", 32'(u_if.starve_err), 32'(m_starve));
    end
    last_gnt = u_if.fu_grant;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    u_if.fu_req = '0;
    u_if.cdb_stall = 1'b0;
    step();
    @(negedge clk);
    chk("rst_valid", 32'(u_if.cdb_valid), 0);
    chk("rst_cnt", 32'(u_if.xfer_count), 0);
    chk("rst_id", 32'(u_if.cdb_id), 0);
    step();
    rst = 1'b1;
  endtask
  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      rst = ($urandom_range(0, 199) != 0);
      u_if.cdb_stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (u_if.fu_req[i] && !last_gnt[i]) begin
          if ($urandom_range(0, 19) == 0) u_if.fu_req[i] = 1'b0;
        end else begin
          u_if.fu_req[i] = 1'($urandom_range(0, 1));
          u_if.fu_id[i]  = IW'($urandom);
          u_if.fu_val[i] = VW'($urandom);
        end
      end
    end
  endtask
  initial begin
    u_if.fu_req = '0;
    u_if.fu_id = '0;
    u_if.fu_val = '0;
    u_if.cdb_stall = 1'b0;
    step();
    chk_en = 1'b1;
    do_reset();
    u_if.fu_req = 4'b0001;
    u_if.fu_id[0] = 4'd3;
    u_if.fu_val[0] = 8'h5A;
    @(negedge clk);
    chk("t1_grant", 32'(u_if.fu_grant), 1);
    step();
    u_if.fu_req = '0;
    @(negedge clk);
    chk("t1_valid", 32'(u_if.cdb_valid), 1);
    chk("t1_id", 32'(u_if.cdb_id), 3);
    chk("t1_val", 32'(u_if.cdb_val), 32'h5A);
    chk("t1_cnt", 32'(u_if.xfer_count), 1);
    step();
    @(negedge clk);
    chk("t1_valid_off", 32'(u_if.cdb_valid), 0);
    chk("t1_id_hold", 32'(u_if.cdb_id), 3);
    do_reset();
    for (int i = 0; i < N; i++) u_if.fu_id[i] = IW'(8 + i);
    u_if.fu_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(u_if.fu_grant), 32'd1 << (k % 4));
      if (k > 0) begin
        chk("rr_valid", 32'(u_if.cdb_valid), 1);
        chk("rr_id", 32'(u_if.cdb_id), 32'(8 + (k - 1) % 4));
      end
      step();
    end
    u_if.fu_req = '0;
    @(negedge clk);
    chk("rr_starve", 32'(u_if.starve_err), 0);
    do_reset();
    u_if.cdb_stall = 1'b1;
    u_if.fu_req = 4'b0110;
    repeat (3) begin
      @(negedge clk);
      chk("stall_grant", 32'(u_if.fu_grant), 0);
      chk("stall_valid", 32'(u_if.cdb_valid), 0);
      step();
    end
    u_if.cdb_stall = 1'b0;
    @(negedge clk);
    chk("unstall_g1", 32'(u_if.fu_grant), 32'b0010);
    step();
    u_if.fu_req = 4'b0100;
    @(negedge clk);
    chk("unstall_g2", 32'(u_if.fu_grant), 32'b0100);
    step();
    u_if.fu_req = 4'b1001;
    @(negedge clk);
    chk("rr_ptr3", 32'(u_if.fu_grant), 32'b1000);
    step();
    u_if.fu_req = 4'b0001;
    @(negedge clk);
    chk("rr_wrap", 32'(u_if.fu_grant), 32'b0001);
    step();
    u_if.fu_req = '0;
    do_reset();
    u_if.fu_req = 4'b1000;
    u_if.fu_id[3] = 4'd5;
    u_if.fu_val[3] = 8'd77;
    step();
    u_if.fu_id[3] = 4'd6;
    u_if.fu_val[3] = 8'd99;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", 32'(u_if.fu_grant), 0);
    chk("mid_rst_valid", 32'(u_if.cdb_valid), 1);
    step();
    @(negedge clk);
    chk("mid_rst_valid0", 32'(u_if.cdb_valid), 0);
    chk("mid_rst_id0", 32'(u_if.cdb_id), 0);
    chk("mid_rst_val0", 32'(u_if.cdb_val), 0);
    chk("mid_rst_cnt0", 32'(u_if.xfer_count), 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 32'(u_if.fu_grant), 32'b1000);
    step();
    u_if.fu_req = '0;
    @(negedge clk);
    chk("post_rst_id", 32'(u_if.cdb_id), 6);
    chk("post_rst_cnt", 32'(u_if.xfer_count), 1);
    random_run(3000);
    rst = 1'b1;
    do_reset();
    u_if.fu_req = 4'b0001;
    u_if.fu_id[0] = 4'd1;
    repeat (65536) @(posedge clk);
    #1;
    u_if.fu_req = '0;
    @(negedge clk);
    chk("wrap_cnt", 32'(u_if.xfer_count), 0);
    chk("wrap_valid", 32'(u_if.cdb_valid), 1);
    chk("wrap_starve", 32'(u_if.starve_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Receiving end of the functional-unit CDB result interface.
- Each FU raises its CDB transmit request with a ROB id and a result value. This block grants exactly one requester per cycle under round-robin priority, then broadcasts the granted result on the common data bus one cycle later.
- The grant output drives each FU's cdb_transmit input, so an FU sees its result accepted in the same cycle it is granted.
- Sits between the FU output stages and the reservation stations and ROB that snoop the CDB.

Parameters:
- NUM_FU, 4, number of FU request ports (2..8).
- ID_W, 4, ROB id width.
- VAL_W, 8, result value width.
- STARVE_LIM, 8, cycles an unstalled request may wait before starve_err is flagged.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- fu_req  input  NUM_FU  per-FU CDB request (the FU's cdb_transmit_out).
- fu_id  input  NUM_FU x ID_W  per-FU ROB id (cdb_id).
- fu_val  input  NUM_FU x VAL_W  per-FU result (cdb_val).
- fu_grant  output  NUM_FU  one-hot-or-zero grant, combinational; drives the FU cdb_transmit.
- cdb_stall  input  1  consumer back-pressure; 1 = no grants this cycle.
- cdb_valid  output  1  registered broadcast valid.
- cdb_id  output  ID_W  registered broadcast ROB id.
- cdb_val  output  VAL_W  registered broadcast value.
- xfer_count  output  16  count of completed transfers; wraps.
- starve_err  output  1  sticky: some request waited more than STARVE_LIM cycles while cdb_stall=0.

Behaviour:
- Reset (rst=0 at edge):
  - Registered outputs: cdb_valid=0, cdb_id=0, cdb_val=0, xfer_count=0, starve_err=0.
  - Round-robin pointer rr_ptr=0; all wait counters 0.
  - fu_grant is forced to 0 while rst=0, regardless of fu_req.
- Grant (combinational):
  - If cdb_stall=1 or fu_req=0, then fu_grant=0.
  - Otherwise grant the first requester i with fu_req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - At most one grant bit is ever high.
- Transfer:
  - A transfer occurs on an edge where fu_grant[i]=1.
  - At that edge: cdb_id<=fu_id[i], cdb_val<=fu_val[i], cdb_valid<=1, xfer_count<=xfer_count+1, rr_ptr<=(i+1) mod NUM_FU.
  - Latency from request to broadcast is 1 cycle when uncontended.
- No transfer:
  - On an edge with no transfer, cdb_valid<=0, cdb_id and cdb_val hold their values, and rr_ptr holds.
  - A broadcast therefore lasts exactly one cycle per transfer.
  - Back-to-back transfers give continuous cdb_valid=1 with a new id and value each cycle.
- Requester obligations:
  - Hold fu_req, fu_id and fu_val stable until granted.
  - Deassert fu_req or present the next result in the cycle after a grant.
  - Dropping fu_req without a grant is legal; no transfer results.
- Stall:
  - cdb_stall=1 suppresses grants in the same cycle.
  - cdb_valid goes 0 on the next edge.
  - rr_ptr and wait counters hold.
- Wait counters:
  - Per port, saturating at STARVE_LIM+1.
  - Increment when fu_req[i]=1, fu_grant[i]=0 and cdb_stall=0.
  - Clear when fu_req[i]=0 or fu_grant[i]=1.
  - A counter exceeding STARVE_LIM sets starve_err. It stays set until reset.
  - Correct round-robin never sets starve_err for NUM_FU <= STARVE_LIM.
- Reset mid-operation: a pending request is not granted. It is re-arbitrated from rr_ptr=0 after reset releases.
- xfer_count wraps from 0xFFFF to 0x0000.

Test Plan:
- Reset, then fu_req=0001, fu_id[0]=3, fu_val[0]=0x5A, stall=0:
  - fu_grant=0001 in the same cycle.
  - Next cycle: cdb_valid=1, cdb_id=3, cdb_val=0x5A, xfer_count=1.
  - Following cycle: cdb_valid=0, with id and val held.
- fu_req=1111 held for 8 cycles from rr_ptr=0:
  - Grants in order 0001,0010,0100,1000,0001,...
  - cdb_valid=1 continuously with the matching ids; starve_err stays 0.
- fu_req=0110 with cdb_stall=1 for 3 cycles, then stall=0:
  - fu_grant=0 and cdb_valid=0 during the stall.
  - Then grant 0010 followed by 0100, with rr_ptr=3 after the second transfer.
- rst=0 asserted while fu_req=1000 and cdb_valid=1:
  - Next cycle cdb_valid=0, cdb_id=0, cdb_val=0, xfer_count=0; fu_grant=0 during reset.
  - After release, grant 1000 in the first cycle.
- Force fu_grant[2] masked (fault-inject model) with fu_req=0100 and stall=0 for 9 cycles -> starve_err=1 and stays 1.
- 65536 consecutive single-port transfers -> xfer_count returns to 0x0000.
